// File: rtl/id_hazard_ctrl_pkg.sv
// Shared ID-stage definitions: RV32 opcodes, issue-FSM state encoding and
// the opcode -> register-usage decode helper.
package id_hazard_ctrl_pkg;

    localparam int unsigned OPCODE_W = 7;
    localparam int unsigned REG_W    = 5;
    localparam int unsigned NUM_REGS = 32;

    localparam logic [OPCODE_W-1:0] OP_R       = 7'b0110011;
    localparam logic [OPCODE_W-1:0] OP_I       = 7'b0010011;
    localparam logic [OPCODE_W-1:0] OP_I_LOAD  = 7'b0000011;
    localparam logic [OPCODE_W-1:0] OP_I_JALR  = 7'b1100111;
    localparam logic [OPCODE_W-1:0] OP_S       = 7'b0100011;
    localparam logic [OPCODE_W-1:0] OP_B       = 7'b1100011;
    localparam logic [OPCODE_W-1:0] OP_U_LUI   = 7'b0110111;
    localparam logic [OPCODE_W-1:0] OP_U_AUIPC = 7'b0010111;
    localparam logic [OPCODE_W-1:0] OP_J_JAL   = 7'b1101111;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    // Which register fields an instruction actually uses.
    typedef struct packed {
        logic rs1;
        logic rs2;
        logic rd;
    } reg_use_t;

    // Unknown opcodes decode as NOP: no sources, no destination.
    function automatic reg_use_t decode_use(input logic [OPCODE_W-1:0] op);
        reg_use_t u;
        u = '0;
        case (op)
            OP_R:                   u = '{rs1: 1'b1, rs2: 1'b1, rd: 1'b1};
            OP_S, OP_B:             u = '{rs1: 1'b1, rs2: 1'b1, rd: 1'b0};
            OP_I, OP_I_LOAD,
            OP_I_JALR:              u = '{rs1: 1'b1, rs2: 1'b0, rd: 1'b1};
            OP_U_LUI, OP_U_AUIPC,
            OP_J_JAL:               u = '{rs1: 1'b0, rs2: 1'b0, rd: 1'b1};
            default:                u = '0;
        endcase
        return u;
    endfunction

endpackage

// File: rtl/id_hazard_ctrl_reg_scoreboard.sv
// Register scoreboard: 32-bit busy vector plus a count of busy entries.
// Ports: set_en/set_idx mark a destination busy, clr_en/clr_idx retire it;
//        busy is the registered vector, count its population.
module reg_scoreboard
    import id_hazard_ctrl_pkg::*;
#(
    parameter int unsigned MAX_INFLIGHT = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              set_en,
    input  logic [4:0]                        set_idx,
    input  logic                              clr_en,
    input  logic [4:0]                        clr_idx,
    output logic [31:0]                       busy,
    output logic [$clog2(MAX_INFLIGHT+1)-1:0] count
);

    localparam int unsigned CNT_W = $clog2(MAX_INFLIGHT + 1);

    logic              set_eff;
    logic              clr_eff;
    logic [31:0]       busy_next;
    logic [CNT_W-1:0]  count_next;

    // x0 is never tracked; a clear only counts when the bit is really busy.
    always_comb begin
        set_eff    = set_en && (set_idx != 5'd0);
        clr_eff    = clr_en && (clr_idx != 5'd0) && busy[clr_idx];
        busy_next  = busy;
        if (clr_eff) busy_next[clr_idx] = 1'b0;
        if (set_eff) busy_next[set_idx] = 1'b1;
        count_next = count + CNT_W'(set_eff) - CNT_W'(clr_eff);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy  <= '0;
            count <= '0;
        end else begin
            busy  <= busy_next;
            count <= count_next;
        end
    end

endmodule

// File: rtl/id_hazard_ctrl.sv
// ID-stage issue controller: stalls on RAW/WAW/capacity hazards against the
// register scoreboard and runs a flush window after a taken branch.
// Ports: i_id_valid/inst describe the ID instruction, i_ex_branch_taken starts
//        a flush, i_wb_we/i_wb_rd retire a destination; o_issue/o_stall/o_flush
//        are combinational controls, o_inflight is the busy-entry count.
module id_hazard_ctrl
    import id_hazard_ctrl_pkg::*;
#(
    parameter int unsigned MAX_INFLIGHT = 4,
    parameter int unsigned FLUSH_LEN    = 2
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              i_id_valid,
    input  logic [31:0]                       inst,
    input  logic                              i_ex_branch_taken,
    input  logic                              i_wb_we,
    input  logic [4:0]                        i_wb_rd,
    output logic                              o_issue,
    output logic                              o_stall,
    output logic                              o_flush,
    output logic [$clog2(MAX_INFLIGHT+1)-1:0] o_inflight
);

    localparam int unsigned CNT_W = $clog2(MAX_INFLIGHT + 1);
    localparam int unsigned FC_W  = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;
    localparam logic [FC_W-1:0] FLUSH_RELOAD = FC_W'(FLUSH_LEN - 1);

    state_t         state, state_next;
    logic [FC_W-1:0] cnt, cnt_next;

    logic [4:0]  rs1, rs2, rd;
    reg_use_t    use_f;
    logic [31:0] busy;
    logic        haz;
    logic        set_en;
    logic        unused_inst_bits;

    assign rd  = inst[11:7];
    assign rs1 = inst[19:15];
    assign rs2 = inst[24:20];
    assign use_f = decode_use(inst[6:0]);
    assign unused_inst_bits = ^{inst[31:25], inst[14:12]};

    // Hazard against registered scoreboard state; a same-cycle writeback
    // does not help until it has landed at the clock edge.
    always_comb begin
        haz = 1'b0;
        if (use_f.rs1 && (rs1 != 5'd0) && busy[rs1]) haz = 1'b1;
        if (use_f.rs2 && (rs2 != 5'd0) && busy[rs2]) haz = 1'b1;
        if (use_f.rd && (rd != 5'd0)) begin
            if (busy[rd])                              haz = 1'b1;
            if (o_inflight == CNT_W'(MAX_INFLIGHT))    haz = 1'b1;
        end
    end

    // Next-state and issue/flush controls.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        o_issue    = 1'b0;
        o_stall    = 1'b0;
        o_flush    = 1'b0;
        case (state)
            ST_RUN: begin
                if (i_ex_branch_taken) begin
                    o_flush    = 1'b1;
                    state_next = ST_FLUSH;
                    cnt_next   = FLUSH_RELOAD;
                end else begin
                    o_issue = i_id_valid & ~haz;
                    o_stall = i_id_valid & haz;
                end
            end
            ST_FLUSH: begin
                o_flush = 1'b1;
                if (i_ex_branch_taken) begin
                    cnt_next = FLUSH_RELOAD;
                end else if (cnt == '0) begin
                    state_next = ST_RUN;
                end else begin
                    cnt_next = cnt - FC_W'(1);
                end
            end
            default: begin
                state_next = ST_RUN;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RUN;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    assign set_en = o_issue & use_f.rd;

    reg_scoreboard #(
        .MAX_INFLIGHT (MAX_INFLIGHT)
    ) u_scoreboard (
        .clk     (clk),
        .rst_n   (rst_n),
        .set_en  (set_en),
        .set_idx (rd),
        .clr_en  (i_wb_we),
        .clr_idx (i_wb_rd),
        .busy    (busy),
        .count   (o_inflight)
    );

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Self-checking bench for id_hazard_ctrl: directed scenarios followed by
// randomized traffic, all compared against a behavioural model.
module tb_id_hazard_ctrl;

    localparam int MAXI = 4;
    localparam int FLEN = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_id_valid = 1'b0;
    logic [31:0] inst = '0;
    logic        i_ex_branch_taken = 1'b0;
    logic        i_wb_we = 1'b0;
    logic [4:0]  i_wb_rd = '0;
    logic        o_issue, o_stall, o_flush;
    logic [2:0]  o_inflight;

    int checks = 0;
    int failures = 0;

    // Model state: busy registers and remaining FLUSH cycles.
    bit [31:0] m_busy;
    int        m_flush_left;
    // Observed outputs from the last step, for directed constant checks.
    logic      obs_issue, obs_stall, obs_flush;
    logic [2:0] obs_infl;

    always #5 clk = ~clk;

    id_hazard_ctrl #(.MAX_INFLIGHT(MAXI), .FLUSH_LEN(FLEN)) dut (
        .clk(clk), .rst_n(rst_n), .i_id_valid(i_id_valid), .inst(inst),
        .i_ex_branch_taken(i_ex_branch_taken), .i_wb_we(i_wb_we),
        .i_wb_rd(i_wb_rd), .o_issue(o_issue), .o_stall(o_stall),
        .o_flush(o_flush), .o_inflight(o_inflight)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input int rd, input int rs1, input int rs2);
        return {7'd0, 5'(rs2), 5'(rs1), 3'd0, 5'(rd), 7'h33};
    endfunction
    function automatic logic [31:0] enc_i(input logic [6:0] op, input int rd, input int rs1, input int imm);
        return {12'(imm), 5'(rs1), 3'b010, 5'(rd), op};
    endfunction
    function automatic logic [31:0] enc_u(input logic [6:0] op, input int rd, input int imm);
        return {20'(imm), 5'(rd), op};
    endfunction

    function automatic int popcount(input bit [31:0] v);
        int n = 0;
        for (int i = 0; i < 32; i++) n += int'(v[i]);
        return n;
    endfunction

    // One cycle: drive at negedge, compare 1 time unit later, advance model at posedge.
    task automatic step(input logic v, input logic [31:0] in, input logic br,
                        input logic we, input logic [4:0] wrd);
        logic [6:0] op;
        bit r1, r2, wr, haz, fl, e_issue, e_stall;
        int rs1, rs2, rd;
        @(negedge clk);
        i_id_valid = v; inst = in; i_ex_branch_taken = br; i_wb_we = we; i_wb_rd = wrd;
        #1;
        op  = in[6:0];
        rd  = int'(in[11:7]); rs1 = int'(in[19:15]); rs2 = int'(in[24:20]);
        r1  = (op inside {7'h33, 7'h23, 7'h63, 7'h13, 7'h03, 7'h67});
        r2  = (op inside {7'h33, 7'h23, 7'h63});
        wr  = (op inside {7'h33, 7'h13, 7'h03, 7'h37, 7'h17, 7'h6f, 7'h67});
        haz = (r1 && rs1 != 0 && m_busy[rs1]) || (r2 && rs2 != 0 && m_busy[rs2]) ||
              (wr && rd != 0 && (m_busy[rd] || popcount(m_busy) == MAXI));
        fl      = br || (m_flush_left > 0);
        e_issue = !fl && v && !haz;
        e_stall = !fl && v && haz;
        obs_issue = o_issue; obs_stall = o_stall; obs_flush = o_flush; obs_infl = o_inflight;
        chk("issue",    32'(o_issue),    32'(e_issue));
        chk("stall",    32'(o_stall),    32'(e_stall));
        chk("flush",    32'(o_flush),    32'(fl));
        chk("inflight", 32'(o_inflight), 32'(popcount(m_busy)));
        @(posedge clk);
        if (we && wrd != 0) m_busy[wrd] = 1'b0;
        if (e_issue && wr && rd != 0) m_busy[rd] = 1'b1;
        if (br) m_flush_left = FLEN;
        else if (m_flush_left > 0) m_flush_left--;
    endtask

    task automatic idle(input logic we, input logic [4:0] wrd);
        step(1'b0, 32'h0, 1'b0, we, wrd);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; i_id_valid = 1'b0; i_ex_branch_taken = 1'b0; i_wb_we = 1'b0;
        #1;
        chk("rst_flush",    32'(o_flush),    32'd0);
        chk("rst_inflight", 32'(o_inflight), 32'd0);
        chk("rst_issue",    32'(o_issue),    32'd0);
        chk("rst_stall",    32'(o_stall),    32'd0);
        m_busy = '0; m_flush_left = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        m_busy = '0; m_flush_left = 0;
        do_reset();
        idle(1'b0, 5'd0);

        // RAW: addi x4,x1,5 then add x3,x4,x2
        step(1, enc_i(7'h13, 4, 1, 5), 0, 0, 0);
        chk("raw_first_issue", 32'(obs_issue), 32'd1);
        step(1, enc_r(3, 4, 2), 0, 0, 0);
        chk("raw_stall", 32'(obs_stall), 32'd1);
        step(1, enc_r(3, 4, 2), 0, 1, 5'd4);
        chk("raw_stall_same_wb", 32'(obs_stall), 32'd1);
        chk("raw_infl_before", 32'(obs_infl), 32'd1);
        step(1, enc_r(3, 4, 2), 0, 0, 0);
        chk("raw_issue_after_wb", 32'(obs_issue), 32'd1);
        chk("raw_infl_after", 32'(obs_infl), 32'd0);
        idle(1'b1, 5'd3);

        // x0 is never a hazard
        step(1, enc_i(7'h13, 0, 1, 1), 0, 0, 0);
        chk("x0_issue1", 32'(obs_issue), 32'd1);
        step(1, enc_r(3, 0, 0), 0, 0, 0);
        chk("x0_issue2", 32'(obs_issue), 32'd1);
        chk("x0_infl", 32'(obs_infl), 32'd0);
        idle(1'b1, 5'd3);

        // Branch flush window: 1 + FLUSH_LEN cycles
        step(1, enc_r(9, 1, 2), 1, 0, 0);
        chk("br_flush0", 32'(obs_flush), 32'd1);
        step(1, enc_r(9, 1, 2), 0, 0, 0);
        chk("br_flush1", 32'(obs_flush), 32'd1);
        step(1, enc_r(9, 1, 2), 0, 0, 0);
        chk("br_flush2", 32'(obs_flush), 32'd1);
        chk("br_no_issue", 32'(obs_issue), 32'd0);
        step(1, enc_r(9, 1, 2), 0, 0, 0);
        chk("br_issue_after", 32'(obs_issue), 32'd1);
        chk("br_flush_done", 32'(obs_flush), 32'd0);
        idle(1'b1, 5'd9);

        // Capacity limit
        for (int r = 5; r <= 8; r++) step(1, enc_i(7'h03, r, 1, 0), 0, 0, 0);
        step(1, enc_i(7'h03, 9, 1, 0), 0, 0, 0);
        chk("cap_stall", 32'(obs_stall), 32'd1);
        chk("cap_infl_full", 32'(obs_infl), 32'd4);
        step(1, enc_i(7'h03, 9, 1, 0), 0, 1, 5'd5);
        step(1, enc_i(7'h03, 9, 1, 0), 0, 0, 0);
        chk("cap_issue", 32'(obs_issue), 32'd1);
        idle(1'b0, 5'd0);
        chk("cap_infl_again", 32'(obs_infl), 32'd4);
        for (int r = 6; r <= 9; r++) idle(1'b1, 5'(r));

        // WAW: lw x5 then lui x5,100; unrelated writebacks do not release it
        step(1, enc_i(7'h03, 5, 1, 0), 0, 0, 0);
        step(1, enc_u(7'h37, 5, 100), 0, 1, 5'd6);
        chk("waw_stall", 32'(obs_stall), 32'd1);
        step(1, enc_u(7'h37, 5, 100), 0, 1, 5'd10);
        step(1, enc_u(7'h37, 5, 100), 0, 1, 5'd5);
        chk("waw_stall_wb_cycle", 32'(obs_stall), 32'd1);
        chk("waw_infl_unchanged", 32'(obs_infl), 32'd1);
        step(1, enc_u(7'h37, 5, 100), 0, 0, 0);
        chk("waw_issue", 32'(obs_issue), 32'd1);
        idle(1'b1, 5'd5);

        // Reset in the middle of FLUSH with x4 busy
        step(1, enc_i(7'h13, 4, 1, 5), 0, 0, 0);
        step(0, 32'h0, 1, 0, 0);
        do_reset();
        step(1, enc_r(3, 4, 2), 0, 0, 0);
        chk("post_rst_issue", 32'(obs_issue), 32'd1);
        idle(1'b1, 5'd3);

        // Randomized traffic on a small register window to provoke hazards
        begin
            logic [6:0] ops [10] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23,
                                     7'h63, 7'h37, 7'h17, 7'h6f, 7'h7f};
            logic [31:0] w;
            for (int n = 0; n < 400; n++) begin
                w = $urandom;
                w[6:0]   = ops[$urandom_range(0, 9)];
                w[11:7]  = 5'($urandom_range(0, 7));
                w[19:15] = 5'($urandom_range(0, 7));
                w[24:20] = 5'($urandom_range(0, 7));
                step(1'($urandom_range(0, 3) != 0), w,
                     1'($urandom_range(0, 15) == 0),
                     1'($urandom_range(0, 1)),
                     5'($urandom_range(0, 7)));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
